// File: rtl/onehot_rr_arbiter_pkg.sv
// Shared types and sizes for the 16-requester one-hot round-robin arbiter.
package onehot_arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int PTR_W   = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage

// File: rtl/onehot_rr_arbiter_if.sv
// Request/grant bundle between requesters/consumer (master) and the arbiter (slave).
interface onehot_rr_arbiter_if;
    import onehot_arb_pkg::*;

    logic     enable;
    req_vec_t req;
    logic     grant_ack;
    req_vec_t grant;
    logic     grant_valid;

    modport master (
        output enable, req, grant_ack,
        input  grant, grant_valid
    );

    modport slave (
        input  enable, req, grant_ack,
        output grant, grant_valid
    );

endinterface

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set bit of (req & ~exclude)
// scanning upward from ptr, wrapping past the top bit.
module rr_pick
    import onehot_arb_pkg::*;
(
    input  req_vec_t         req,
    input  logic [PTR_W-1:0] ptr,
    input  req_vec_t         exclude,
    output logic             found,
    output logic [PTR_W-1:0] winner_idx,
    output req_vec_t         winner_onehot
);

    req_vec_t               masked;
    logic [2*NUM_REQ-1:0]   fwd_dbl;
    req_vec_t               rot;
    req_vec_t               rot_lsb;
    logic [PTR_W-1:0]       rot_idx;
    logic [2*NUM_REQ-1:0]   back_dbl;

    // Rotate so ptr lands at bit 0, take the lowest set bit, rotate the result back.
    always_comb begin
        masked   = req & ~exclude;
        fwd_dbl  = {masked, masked} >> ptr;
        rot      = fwd_dbl[NUM_REQ-1:0];
        rot_lsb  = rot & (~rot + 1'b1);
        rot_idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) rot_idx = PTR_W'(i);
        end
        back_dbl      = {rot_lsb, rot_lsb} << ptr;
        winner_onehot = back_dbl[2*NUM_REQ-1:NUM_REQ];
        winner_idx    = rot_idx + ptr;   // 4-bit add wraps 15 -> 0
        found         = |masked;
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter, 16 requesters. Registered one-hot grant held until ack;
// on ack it re-arbitrates in the same cycle (no bubble) from winner+1,
// excluding the requester just served.
module onehot_rr_arbiter
    import onehot_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    onehot_rr_arbiter_if.slave   bus
);

    arb_state_t       state, state_n;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic [PTR_W-1:0] win_idx, win_idx_n;
    req_vec_t         grant_r, grant_n;
    logic             valid_r, valid_n;

    logic [PTR_W-1:0] pick_ptr;
    req_vec_t         pick_excl;
    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    req_vec_t         pick_onehot;

    rr_pick u_pick (
        .req           (bus.req),
        .ptr           (pick_ptr),
        .exclude       (pick_excl),
        .found         (pick_found),
        .winner_idx    (pick_idx),
        .winner_onehot (pick_onehot)
    );

    // State, pointer and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            win_idx <= '0;
            grant_r <= '0;
            valid_r <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            win_idx <= win_idx_n;
            grant_r <= grant_n;
            valid_r <= valid_n;
        end
    end

    // Next-state: arbitrate from IDLE, hold in GRANT until ack, then chain or drop.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        win_idx_n = win_idx;
        grant_n   = grant_r;
        valid_n   = valid_r;
        pick_ptr  = ptr;
        pick_excl = '0;
        unique case (state)
            IDLE: begin
                if (bus.enable && pick_found) begin
                    state_n   = GRANT;
                    win_idx_n = pick_idx;
                    grant_n   = pick_onehot;
                    valid_n   = 1'b1;
                end
            end
            GRANT: begin
                // Chained pick already uses the post-ack pointer and skips the acked bit.
                pick_ptr  = win_idx + 1'b1;
                pick_excl = grant_r;
                if (bus.grant_ack) begin
                    ptr_n = win_idx + 1'b1;
                    if (bus.enable && pick_found) begin
                        win_idx_n = pick_idx;
                        grant_n   = pick_onehot;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        valid_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                valid_n = 1'b0;
            end
        endcase
    end

    assign bus.grant       = grant_r;
    assign bus.grant_valid = valid_r;

    // Downstream encoder relies on a clean one-hot-or-zero grant matching valid.
    a_onehot_grant: assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant_r) && ((grant_r != '0) == valid_r));

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_onehot_rr_arbiter;
    import onehot_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    onehot_rr_arbiter_if bus ();

    onehot_rr_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_valid = 1'b0;
    int m_idx   = 0;
    int m_ptr   = 0;

    function automatic int pick(input logic [15:0] rq, input int p, input logic [15:0] excl);
        for (int i = 0; i < 16; i++) begin
            int b;
            b = (p + i) % 16;
            if (rq[b] && !excl[b]) return b;
        end
        return -1;
    endfunction

    function automatic logic [15:0] m_grant();
        logic [15:0] g;
        g = '0;
        if (m_valid) g[m_idx] = 1'b1;
        return g;
    endfunction

    // Apply one cycle of inputs, advance the model across the edge, settle.
    task automatic step(input logic r, input logic en, input logic [15:0] rq, input logic ak);
        int w;
        logic [15:0] excl;
        reset         = r;
        bus.enable    = en;
        bus.req       = rq;
        bus.grant_ack = ak;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_idx = 0; m_ptr = 0;
        end else if (!m_valid) begin
            w = pick(rq, m_ptr, 16'h0000);
            if (en && w >= 0) begin m_valid = 1'b1; m_idx = w; end
        end else if (ak) begin
            m_ptr = (m_idx + 1) % 16;
            excl = '0;
            excl[m_idx] = 1'b1;
            w = pick(rq, m_ptr, excl);
            if (en && w >= 0) m_idx = w;
            else m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 1'b1, 16'hFFFF, 1'b0);
            checks++;
            if (bus.grant !== 16'h0000 || bus.grant_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got grant=%h valid=%b exp 0000/0", c, bus.grant, bus.grant_valid);
            end
        end
        step(1'b0, 1'b1, 16'hFFFF, 1'b0);
        checks++;
        if (bus.grant !== 16'h0001 || bus.grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant got %h/%b exp 0001/1", bus.grant, bus.grant_valid);
        end
    endtask

    task automatic test_hold();
        logic [15:0] rq_seq [5] = '{16'h0020, 16'h0000, 16'h0F0F, 16'hFFDF, 16'h0000};
        do_reset();
        step(1'b0, 1'b1, 16'h0020, 1'b0);
        checks++;
        if (bus.grant !== 16'h0020 || bus.grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_first got %h/%b exp 0020/1", bus.grant, bus.grant_valid);
        end
        for (int c = 0; c < 5; c++) begin
            step(1'b0, c[0], rq_seq[c], 1'b0);
            checks++;
            if (bus.grant !== 16'h0020 || bus.grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_cyc%0d got %h/%b exp 0020/1", c, bus.grant, bus.grant_valid);
            end
        end
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        checks++;
        if (bus.grant !== 16'h0000 || bus.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_ack_drop got %h/%b exp 0000/0", bus.grant, bus.grant_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        do_reset();
        step(1'b0, 1'b1, 16'hFFFF, 1'b0);
        checks++;
        if (bus.grant !== 16'h0001) begin
            errors++;
            $display("FAIL b2b_first got %h exp 0001", bus.grant);
        end
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b1, 16'hFFFF, 1'b1);
            exp = 16'h0001 << ((k + 1) % 16);
            checks++;
            if (bus.grant !== exp || bus.grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ack%0d got %h/%b exp %h/1", k, bus.grant, bus.grant_valid, exp);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b0, 1'b1, 16'h8001, 1'b0);
        checks++;
        if (bus.grant !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_first got %h exp 0001", bus.grant);
        end
        step(1'b0, 1'b1, 16'h8001, 1'b1);
        checks++;
        if (bus.grant !== 16'h8000) begin
            errors++;
            $display("FAIL wrap_second got %h exp 8000", bus.grant);
        end
        step(1'b0, 1'b1, 16'h8001, 1'b1);
        checks++;
        if (bus.grant !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_third got %h exp 0001", bus.grant);
        end
        // Sole requester may win again after a gap
        step(1'b0, 1'b1, 16'h0001, 1'b1);
        step(1'b0, 1'b1, 16'h0001, 1'b0);
        checks++;
        if (bus.grant !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_sole_rewin got %h exp 0001", bus.grant);
        end
    endtask

    task automatic test_enable();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 16'h0100, 1'b0);
            checks++;
            if (bus.grant !== 16'h0000 || bus.grant_valid !== 1'b0) begin
                errors++;
                $display("FAIL en_off_cyc%0d got %h/%b exp 0000/0", c, bus.grant, bus.grant_valid);
            end
        end
        step(1'b0, 1'b1, 16'h0100, 1'b0);
        checks++;
        if (bus.grant !== 16'h0100) begin
            errors++;
            $display("FAIL en_on got %h exp 0100", bus.grant);
        end
        step(1'b0, 1'b0, 16'hFFFF, 1'b1);
        checks++;
        if (bus.grant !== 16'h0000 || bus.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_off_ack got %h/%b exp 0000/0", bus.grant, bus.grant_valid);
        end
        step(1'b0, 1'b0, 16'hFFFF, 1'b0);
        checks++;
        if (bus.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_off_idle got valid=%b exp 0", bus.grant_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b0, 1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 1'b1, 16'hFFFF, 1'b1);   // now 0002 held, ptr=1
        step(1'b1, 1'b1, 16'hFFFF, 1'b1);
        checks++;
        if (bus.grant !== 16'h0000 || bus.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got %h/%b exp 0000/0", bus.grant, bus.grant_valid);
        end
        step(1'b0, 1'b1, 16'hFFFF, 1'b0);
        checks++;
        if (bus.grant !== 16'h0001) begin
            errors++;
            $display("FAIL mid_reset_ptr0 got %h exp 0001", bus.grant);
        end
        step(1'b0, 1'b0, 16'h0000, 1'b1);   // back to IDLE, ptr=1
        step(1'b0, 1'b0, 16'h0000, 1'b1);   // ack in IDLE: ignored
        checks++;
        if (bus.grant !== 16'h0000 || bus.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack got %h/%b exp 0000/0", bus.grant, bus.grant_valid);
        end
        step(1'b0, 1'b1, 16'hFFFF, 1'b0);
        checks++;
        if (bus.grant !== 16'h0002) begin
            errors++;
            $display("FAIL idle_ack_ptr got %h exp 0002", bus.grant);
        end
    endtask

    task automatic test_random();
        logic [15:0] rq;
        logic [15:0] eg;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0: rq = 16'h0001 << $urandom_range(0, 15);
                1: rq = 16'($urandom) & 16'($urandom);
                2: rq = 16'($urandom);
                default: rq = 16'h0000;
            endcase
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), rq, 1'($urandom));
            eg = m_grant();
            checks++;
            if (bus.grant !== eg || bus.grant_valid !== m_valid) begin
                errors++;
                $display("FAIL rand_cyc%0d got %h/%b exp %h/%b", c, bus.grant, bus.grant_valid, eg, m_valid);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.req       = '0;
        bus.grant_ack = 1'b0;
        test_reset();
        test_hold();
        test_back_to_back();
        test_wrap();
        test_enable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
